flexbex_ibex_fetch_queue: RTL and testbench

Parametrised instruction fetch front end for the flexbex core: a configurable-depth prefetch FIFO with multiple outstanding memory requests, branch flush with late-response discard, and a realigner that extracts 16-bit compressed and 32-bit instructions from word-aligned fetch data, including 32-bit instructions that straddle a word boundary. It sits between the instruction memory port and the decompressor/IF-ID register. It replaces the single-slot prefetch path with a deeper, error-aware queue.

---
 rtl/flexbex_ibex_fetch_queue.sv | 164 ++++++++++++++++
 tb/tb_flexbex_ibex_fetch_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexbex_ibex_fetch_queue.sv
// Instruction prefetch queue with outstanding-request credit, branch flush and 16/32-bit realigner.
// Define FLEXBEX_FETCH_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module flexbex_ibex_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_addr_o,
  output logic        out_compressed_o,
  output logic        out_err_o,
  output logic        busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]    r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_mem_err;
  logic [AW-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]  r_count, r_out_q, r_disc_q;
  logic           r_started, r_off;
  logic [31:0]    r_fa, r_out_addr;

  logic           w_gnt, w_drop, w_byp, w_push, w_pop_h, w_pop, w_mem_pop, w_accept;
  logic           w_h_ok, w_two, w_h_err, w_n_err;
  logic [31:0]    w_h_data, w_n_data;
  logic [AW-1:0]  w_nx_ptr;
  logic [CW:0]    w_credit;
  logic           w_valid, w_comp, w_err, w_off_nx;
  logic [31:0]    w_instr;
  logic           w_unused;

  assign w_unused = branch_addr_i[0];

  // Credit counts queued words plus live requests; requests doomed to be discarded free no slot.
  assign w_credit    = {1'b0, r_count} + {1'b0, r_out_q} - {1'b0, r_disc_q};
  assign instr_req_o = r_started & req_i & (r_out_q < CW'(MAX_OUT)) &
                       (w_credit < (CW+1)'(DEPTH));
  assign instr_addr_o = r_fa;
  assign w_gnt   = instr_req_o & instr_gnt_i;
  assign w_drop  = (r_disc_q != '0);
  assign busy_o  = (r_out_q != '0) | instr_req_o;

`ifdef FLEXBEX_FETCH_BYPASS_EN
  assign w_byp = (r_count == '0) & instr_rvalid_i & ~w_drop & ~branch_i;
`else
  assign w_byp = 1'b0;
`endif

  assign w_nx_ptr = r_rd_ptr + AW'(1);
  assign w_h_data = w_byp ? instr_rdata_i : r_mem_data[r_rd_ptr];
  assign w_h_err  = w_byp ? instr_err_i : r_mem_err[r_rd_ptr];
  assign w_n_data = r_mem_data[w_nx_ptr];
  assign w_n_err  = r_mem_err[w_nx_ptr];
  assign w_h_ok   = w_byp | (r_count != '0);
  assign w_two    = (r_count >= CW'(2));

  always_comb begin
    w_valid  = 1'b0;
    w_instr  = '0;
    w_comp   = 1'b0;
    w_err    = 1'b0;
    w_pop_h  = 1'b0;
    w_off_nx = r_off;
    if (w_h_ok) begin
      if (w_h_err) begin
        // Errored word is reported whole and resynchronises the realigner to offset 0.
        w_valid  = 1'b1;
        w_err    = 1'b1;
        w_instr  = w_h_data;
        w_pop_h  = 1'b1;
        w_off_nx = 1'b0;
      end else if (!r_off) begin
        w_valid = 1'b1;
        if (w_h_data[1:0] != 2'b11) begin
          w_comp   = 1'b1;
          w_instr  = {16'h0, w_h_data[15:0]};
          w_off_nx = 1'b1;
        end else begin
          w_instr = w_h_data;
          w_pop_h = 1'b1;
        end
      end else if (w_h_data[17:16] != 2'b11) begin
        w_valid  = 1'b1;
        w_comp   = 1'b1;
        w_instr  = {16'h0, w_h_data[31:16]};
        w_pop_h  = 1'b1;
        w_off_nx = 1'b0;
      end else if (w_two) begin
        w_valid = 1'b1;
        w_err   = w_n_err;
        w_instr = {w_n_data[15:0], w_h_data[31:16]};
        w_pop_h = 1'b1;
      end
    end
  end

  assign out_valid_o      = w_valid;
  assign out_instr_o      = w_instr;
  assign out_compressed_o = w_comp;
  assign out_err_o        = w_err;
  assign out_addr_o       = r_out_addr;

  assign w_accept  = w_valid & out_ready_i & ~branch_i;
  assign w_pop     = w_accept & w_pop_h;
  assign w_mem_pop = w_pop & ~w_byp;
  assign w_push    = instr_rvalid_i & ~w_drop & ~branch_i & ~(w_byp & w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= instr_rdata_i;
      r_mem_err[r_wr_ptr]  <= instr_err_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started  <= 1'b0;
      r_off      <= 1'b0;
      r_fa       <= '0;
      r_out_addr <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_out_q    <= '0;
      r_disc_q   <= '0;
    end else if (branch_i) begin
      r_started  <= 1'b1;
      r_fa       <= {branch_addr_i[31:2], 2'b00};
      r_off      <= branch_addr_i[1];
      r_out_addr <= {branch_addr_i[31:1], 1'b0};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_out_q    <= r_out_q + CW'(w_gnt) - CW'(instr_rvalid_i);
      r_disc_q   <= r_out_q + CW'(w_gnt) - CW'(instr_rvalid_i);
    end else begin
      if (w_gnt) r_fa <= r_fa + 32'd4;
      r_out_q <= r_out_q + CW'(w_gnt) - CW'(instr_rvalid_i);
      if (instr_rvalid_i && w_drop) r_disc_q <= r_disc_q - CW'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_mem_pop) r_rd_ptr <= w_nx_ptr;
      r_count <= r_count + CW'(w_push) - CW'(w_mem_pop);
      if (w_accept) begin
        r_off      <= w_off_nx;
        r_out_addr <= r_out_addr + (w_comp ? 32'd2 : 32'd4);
      end
    end
  end

endmodule

// File: tb/tb_flexbex_ibex_fetch_queue.sv
// Bench for flexbex_ibex_fetch_queue: in-order memory model plus an instruction-stream
// reference that walks the program image halfword by halfword from each branch target.
`timescale 1ns/1ps
module tb_flexbex_ibex_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_i, branch_i, instr_gnt_i, instr_rvalid_i, instr_err_i, out_ready_i;
  logic [31:0] branch_addr_i, instr_rdata_i;
  logic        instr_req_o, out_valid_o, out_compressed_o, out_err_o, busy_o;
  logic [31:0] instr_addr_o, out_instr_o, out_addr_o;

  flexbex_ibex_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
    .out_addr_o(out_addr_o), .out_compressed_o(out_compressed_o), .out_err_o(out_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  bit [31:0] img [bit [31:0]];
  bit        errimg [bit [31:0]];
  logic [31:0] memq [$];
  logic [31:0] mem_a;
  logic [31:0] hold_addr = 32'hFFFF_FFFF;
  bit          hold_all = 1'b0, slow = 1'b0, gnt_mode = 1'b0;
  int          cyc = 0;

  int checks = 0, errors = 0;
  int tb_out = 0, grants_br = 0, acc_cnt = 0;
  logic [31:0] exp_pc = '0;
  bit          halted = 1'b1;
  logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_br = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] m_w, m_ei;
  logic [15:0] m_lo;
  logic        m_ec, m_ee;

  function automatic logic [31:0] img_w(input logic [31:0] a);
    bit [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (img.exists(wa)) return img[wa];
    return (wa * 32'h9E37_79B1) ^ 32'h3C6E_F372;
  endfunction

  function automatic logic img_e(input logic [31:0] a);
    bit [31:0] wa;
    wa = {a[31:2], 2'b00};
    return errimg.exists(wa);
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = img_w(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: answers granted addresses in order, one cycle or more after the grant.
  always begin
    @(posedge clk); #1;
    cyc++;
    instr_gnt_i = gnt_mode ? (cyc % 7 != 3) : 1'b1;
    if (memq.size() > 0 && !hold_all && memq[0] != hold_addr && !(slow && (cyc % 3 == 0))) begin
      mem_a          = memq.pop_front();
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = img_w(mem_a);
      instr_err_i    = img_e(mem_a);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'hDEAD_BEEF;
      instr_err_i    = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tb_out != 0) chk("busy_outstanding", busy_o, 1'b1);
      else chk("busy_idle", busy_o, instr_req_o);
      if (instr_req_o) chk("max_outstanding", (tb_out < MAX_OUT), 1'b1);
      chk("instr_addr_align", instr_addr_o[1:0], 2'b00);
      chk("out_addr_lsb", out_addr_o[0], 1'b0);
      if (prev_req && !prev_gnt && !prev_br && req_i) begin
        chk("req_held", instr_req_o, 1'b1);
        chk("req_addr_held", instr_addr_o, prev_addr);
      end
      if (branch_i) begin
        exp_pc    = {branch_addr_i[31:1], 1'b0};
        halted    = 1'b0;
        grants_br = 0;
      end else begin
        if (out_valid_o && out_ready_i && !halted) begin
          m_lo = hw(exp_pc);
          if (img_e(exp_pc)) begin
            m_ei = img_w(exp_pc); m_ec = 1'b0; m_ee = 1'b1; halted = 1'b1;
          end else if (m_lo[1:0] != 2'b11) begin
            m_ei = {16'h0, m_lo}; m_ec = 1'b1; m_ee = 1'b0;
          end else begin
            m_ei = {hw(exp_pc + 32'd2), m_lo}; m_ec = 1'b0; m_ee = img_e(exp_pc + 32'd2);
          end
          chk("stream_instr", out_instr_o, m_ei);
          chk("stream_addr", out_addr_o, exp_pc);
          chk("stream_compressed", out_compressed_o, m_ec);
          chk("stream_err", out_err_o, m_ee);
          exp_pc = exp_pc + (m_ec ? 32'd2 : 32'd4);
          acc_cnt++;
        end
        if (instr_req_o && instr_gnt_i) grants_br++;
      end
      if (instr_req_o && instr_gnt_i) memq.push_back(instr_addr_o);
      tb_out = tb_out + int'(instr_req_o && instr_gnt_i) - int'(instr_rvalid_i);
      prev_req  = instr_req_o;
      prev_gnt  = instr_gnt_i;
      prev_br   = branch_i;
      prev_addr = instr_addr_o;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic branch_to(input logic [31:0] a);
    step();
    branch_i      = 1'b1;
    branch_addr_i = a;
    step();
    branch_i      = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid_o) break;
    end
    chk({nm, "_valid"}, out_valid_o, 1'b1);
  endtask

  task automatic wait_acc(input int n);
    int tgt;
    tgt = acc_cnt + n;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (acc_cnt >= tgt) break;
    end
    chk("stream_progress", acc_cnt, tgt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0; out_ready_i = 1'b1;
    instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    img[32'h080] = 32'h0041_0113;
    img[32'h100] = 32'h0513_4501;
    img[32'h104] = 32'hABCD_0000;
    img[32'h200] = 32'h4505_4501;
    img[32'h300] = 32'h1111_1111;
    img[32'h304] = 32'h2222_2222;
    img[32'h400] = 32'h0000_0413;
    img[32'h600] = 32'h1234_5678;
    errimg[32'h600] = 1'b1;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_req", instr_req_o, 1'b0);
    chk("rst_instr_addr", instr_addr_o, 32'h0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_instr", out_instr_o, 32'h0);
    chk("rst_out_addr", out_addr_o, 32'h0);
    chk("rst_out_compressed", out_compressed_o, 1'b0);
    chk("rst_out_err", out_err_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_req_before_branch", instr_req_o, 1'b0);

    // Aligned 32-bit instruction after the first branch
    branch_to(32'h80);
    @(negedge clk);
    chk("t1_req_after_branch", instr_req_o, 1'b1);
    chk("t1_addr_after_branch", instr_addr_o, 32'h80);
    wait_valid("t1");
    chk("t1_instr", out_instr_o, 32'h0041_0113);
    chk("t1_addr", out_addr_o, 32'h80);
    chk("t1_compressed", out_compressed_o, 1'b0);
    wait_acc(5);

    // Straddling 32-bit instruction at an odd halfword
    branch_to(32'h102);
    wait_valid("t2");
    chk("t2_instr", out_instr_o, 32'h0000_0513);
    chk("t2_addr", out_addr_o, 32'h102);
    chk("t2_compressed", out_compressed_o, 1'b0);
    wait_acc(4);

    // Two compressed instructions in one word
    branch_to(32'h200);
    wait_valid("t3");
    chk("t3_instr0", out_instr_o, 32'h0000_4501);
    chk("t3_addr0", out_addr_o, 32'h200);
    chk("t3_comp0", out_compressed_o, 1'b1);
    @(negedge clk);
    chk("t3_valid1", out_valid_o, 1'b1);
    chk("t3_instr1", out_instr_o, 32'h0000_4505);
    chk("t3_addr1", out_addr_o, 32'h202);
    chk("t3_comp1", out_compressed_o, 1'b1);

    // Branch with two requests in flight: late responses must vanish
    hold_all = 1'b1;
    branch_to(32'h300);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tb_out == MAX_OUT) break;
    end
    chk("t4_outstanding", tb_out, MAX_OUT);
    branch_to(32'h400);
    hold_all = 1'b0;
    wait_valid("t4");
    chk("t4_addr", out_addr_o, 32'h400);
    chk("t4_instr", out_instr_o, 32'h0000_0413);
    wait_acc(4);

    // Consumer stall: fill and stop requesting, then drain without loss
    out_ready_i = 1'b0;
    branch_to(32'h500);
    repeat (20) @(negedge clk);
    chk("t5_req_stopped", instr_req_o, 1'b0);
    chk("t5_busy", busy_o, 1'b0);
    chk("t5_grants", grants_br, DEPTH);
    chk("t5_valid", out_valid_o, 1'b1);
    chk("t5_addr", out_addr_o, 32'h500);
    step();
    out_ready_i = 1'b1;
    wait_acc(10);

    // Error word at offset 1, next word held back
    hold_addr = 32'h604;
    branch_to(32'h602);
    wait_valid("t6");
    chk("t6_err", out_err_o, 1'b1);
    chk("t6_instr", out_instr_o, 32'h1234_5678);
    chk("t6_addr", out_addr_o, 32'h602);
    chk("t6_compressed", out_compressed_o, 1'b0);
    hold_addr = 32'hFFFF_FFFF;
    branch_to(32'h700);
    wait_valid("t6b");
    chk("t6b_err", out_err_o, 1'b0);
    chk("t6b_addr", out_addr_o, 32'h700);
    wait_acc(5);

    // Irregular grants, responses, ready and req; odd branch address; address wrap
    slow = 1'b1;
    gnt_mode = 1'b1;
    branch_to(32'h1001);
    for (int i = 0; i < 120; i++) begin
      step();
      out_ready_i = (i % 5 != 1);
      req_i       = !(i >= 40 && i < 50);
      if (i == 80) begin
        branch_i      = 1'b1;
        branch_addr_i = 32'hFFFF_FFF6;
      end else begin
        branch_i = 1'b0;
      end
    end
    step();
    req_i = 1'b1;
    out_ready_i = 1'b1;
    wait_acc(12);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
